// File: rtl/uart_pkg.sv
// Shared UART definitions: issue/receive FSM state encodings and default payload width.
package uart_pkg;

    localparam int unsigned UART_PAYLOAD_BITS = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } uart_fsm_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Circular byte buffer for the UART TX path: wr/rd pointers wrap modulo DEPTH,
// occupancy count is tracked separately and full/empty/level are registered.
module uart_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd,
    input  logic                    flush,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             wr_ok;
    logic             rd_ok;

    // Write is gated on the registered full flag, so a same-cycle pop never frees a slot for it.
    assign wr_ok   = wr && !full && !flush;
    assign rd_ok   = rd && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (wr_ok && !rd_ok) begin
            count_next = count + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART TX byte buffer and issue engine: queues bytes and hands them one at a time to the
// transmitter over en/busy. Optional flush port enabled by defining UART_TX_FIFO_FLUSH_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS = UART_PAYLOAD_BITS,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [PAYLOAD_BITS-1:0]  wr_data,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic                     flush,
`endif
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]  uart_tx_data,
    input  logic                     uart_tx_busy
);

    uart_fsm_e               state;
    uart_fsm_e               state_next;
    logic                    pop;
    logic                    flush_i;
    logic [PAYLOAD_BITS-1:0] head_data;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    uart_fifo_mem #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .resetn  (resetn),
        .wr      (wr_en),
        .wr_data (wr_data),
        .rd      (pop),
        .flush   (flush_i),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (uart_tx_busy)  state_next = WAIT_DONE;
            WAIT_DONE: if (!uart_tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Flush leaves the FSM alone, so a byte already popped still completes its frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            overflow     <= 1'b0;
        end else begin
            state      <= state_next;
            uart_tx_en <= (state_next == ISSUE);
            overflow   <= wr_en && full && !flush_i;
            if (pop) begin
                uart_tx_data <= head_data;
            end
        end
    end

endmodule
